// File: rtl/mvm_pkg.sv
// Shared types and constants for the MVM input-stream transmitter.
package mvm_pkg;

    localparam int unsigned K_DEF  = 8;
    localparam int unsigned W_DEF  = 14;
    localparam int unsigned AW_DEF = 7;

    typedef logic signed [W_DEF-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } tx_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/mvm_stream_tx_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR (x^16+x^14+x^13+x^11+1), advances when step=1.
module lfsr16
    import mvm_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        step,
    output logic [15:0] q
);

    logic fb;

    always_comb begin
        fb = q[15] ^ q[13] ^ q[12] ^ q[10];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/mvm_stream_tx.sv
// Buffers a KxK matrix plus K-vector and streams it to the MVM input port.
// Optional stall injection on the stream when MVM_TX_BUBBLE_EN is defined.
module mvm_stream_tx
    import mvm_pkg::*;
#(
    parameter int unsigned K  = K_DEF,
    parameter int unsigned W  = W_DEF,
    parameter int unsigned AW = AW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          start,
    input  logic          send_matrix,
    output logic          busy,
    output logic          done,
    output logic          input_valid,
    input  logic          input_ready,
    output logic [W-1:0]  input_data,
    output logic          new_matrix
);

    localparam int unsigned N    = K * K + K;
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic [AW-1:0] VEC0 = AW'(K * K);

    tx_state_t     state, state_n;
    logic [AW-1:0] cnt, cnt_n;
    logic          smat, smat_n;
    logic          present;

    logic [W-1:0]  mem [N];

    // Writes only land while idle, so the buffer is frozen for a whole transfer.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && {1'b0, wr_addr} < (AW + 1)'(N)) begin
            mem[wr_addr] <= wr_data;
        end
    end

`ifdef MVM_TX_BUBBLE_EN
    logic [15:0] lfsr_q;
    logic        pending;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (state == SEND),
        .q     (lfsr_q)
    );

    // An element already shown must stay valid until it is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
        end else begin
            pending <= (state == SEND) && input_valid && !input_ready;
        end
    end

    always_comb begin
        present = pending | lfsr_q[0];
    end
`else
    always_comb begin
        present = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            smat  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            smat  <= smat_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        smat_n      = smat;
        busy        = 1'b0;
        done        = 1'b0;
        input_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    smat_n  = send_matrix;
                    cnt_n   = send_matrix ? '0 : VEC0;
                    state_n = SEND;
                end
            end
            SEND: begin
                busy        = 1'b1;
                input_valid = present;
                if (input_valid && input_ready) begin
                    if (cnt == LAST) begin
                        state_n = DONE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        input_data = input_valid ? mem[cnt] : '0;
        new_matrix = input_valid && smat && (cnt == '0);
    end

endmodule

// File: tb/tb_mvm_stream_tx.sv
// Directed bench for mvm_stream_tx: full, vector-only, backpressure, busy-time writes, reset abort, signed extremes.
module tb_mvm_stream_tx;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [6:0]        wr_addr;
    logic [13:0]       wr_data;
    logic              start;
    logic              send_matrix;
    logic              busy;
    logic              done;
    logic              input_valid;
    logic              input_ready;
    logic signed [13:0] input_data;
    logic              new_matrix;

    int total = 0;
    int bad   = 0;
    int exp_mem [72];
    int cap [72];

    mvm_stream_tx #(.K(8), .W(14), .AW(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .send_matrix (send_matrix),
        .busy        (busy),
        .done        (done),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .input_data  (input_data),
        .new_matrix  (new_matrix)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 7'(a);
        wr_data = 14'(d);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (a < 72) exp_mem[a] = d;
    endtask

    task automatic do_start(input bit sm);
        start       = 1'b1;
        send_matrix = sm;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready=1, 1: random ready with forced stall on element 5,
    // 2: write+start injected mid-transfer; abort_at>=0 resets at that handshake count
    task automatic collect(input bit sm, input int mode, input int abort_at);
        int idx;
        int cycles;
        int stall;
        int hs;
        bit pend;
        bit inj;
        logic signed [13:0] pdat;
        idx = sm ? 0 : 64;
        cycles = 0; stall = 0; hs = 0; pend = 0; inj = 0; pdat = '0;
        while (idx < 72 && cycles < 2000) begin
            if (mode == 1) begin
                if (idx == 4 && stall < 3) begin
                    input_ready = 1'b0;
                    stall++;
                end else begin
                    input_ready = 1'($urandom_range(0, 1));
                end
            end else begin
                input_ready = 1'b1;
            end
            if (mode == 2) begin
                if (idx == 10 && !inj) begin
                    wr_en = 1'b1; wr_addr = 7'd0; wr_data = 14'h2000;
                    start = 1'b1; send_matrix = 1'b0; inj = 1;
                end else begin
                    wr_en = 1'b0; start = 1'b0;
                end
            end
            if (hs == abort_at) begin
                reset = 1'b0;
                #1;
                chk("abort_valid", input_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_data", input_data, 0);
                chk("abort_newm", new_matrix, 0);
                return;
            end
            chk("busy_send", busy, 1);
            if (mode == 0) chk("valid_nobubble", input_valid, 1);
            if (pend) begin
                chk("hold_valid", input_valid, 1);
                chk("hold_data", input_data, pdat);
            end
            if (input_valid) begin
                chk($sformatf("data[%0d]", idx), input_data, exp_mem[idx]);
                chk($sformatf("newm[%0d]", idx), new_matrix, (sm && idx == 0) ? 1 : 0);
                cap[idx] = input_data;
                if (input_ready) begin
                    idx++;
                    hs++;
                end
            end
            pend = input_valid && !input_ready;
            pdat = input_data;
            @(posedge clk); #1;
            cycles++;
        end
        wr_en = 1'b0;
        start = 1'b0;
        chk("complete", idx, 72);
        if (mode == 0) chk("cycles", cycles, sm ? 72 : 8);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", input_valid, 0);
        @(posedge clk); #1;
        chk("done_clear", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_valid", input_valid, 0);
    endtask

    initial begin
        int y;
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; send_matrix = 1'b0; input_ready = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", input_valid, 0);
        chk("rst_data", input_data, 0);
        chk("rst_newm", new_matrix, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 64; i++) wr(i, i + 1);
        for (int i = 0; i < 8; i++) wr(64 + i, 100 + i);

        // full matrix + vector
        do_start(1'b1);
        collect(1'b1, 0, -1);

        // vector only
        do_start(1'b0);
        collect(1'b0, 0, -1);

        // backpressure
        do_start(1'b1);
        collect(1'b1, 1, -1);

        // write and start while busy must be ignored
        do_start(1'b1);
        collect(1'b1, 2, -1);
        do_start(1'b1);
        collect(1'b1, 0, -1);

        // reset after 20 handshakes
        do_start(1'b1);
        collect(1'b1, 0, 20);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold_done", done, 0);
            chk("rst_hold_valid", input_valid, 0);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", done, 0);
        do_start(1'b1);
        collect(1'b1, 0, -1);

        // write and start in the same idle cycle
        wr_en = 1'b1; wr_addr = 7'd64; wr_data = 14'd55;
        start = 1'b1; send_matrix = 1'b0;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        exp_mem[64] = 55;
        collect(1'b0, 0, -1);

        // out-of-range write must not disturb anything readable
        wr(72, 1234);
        wr(127, 4321);

        // signed extremes
        for (int i = 0; i < 64; i++) wr(i, (i % 2 == 0) ? -8192 : 8191);
        for (int i = 0; i < 8; i++) wr(64 + i, -1);
        do_start(1'b1);
        collect(1'b1, 0, -1);
        for (int r = 0; r < 8; r++) begin
            y = 0;
            for (int c = 0; c < 8; c++) y += cap[r * 8 + c] * cap[64 + c];
            chk($sformatf("mvm_out[%0d]", r), y, 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
